// File: rtl/regfile_scoreboard.sv
// Integer register file with write-through bypass and a per-register pending-load scoreboard.
// Optional macro REGFILE_RESET_CLEAR_EN: clear x1..x(NREGS-1) on reset; otherwise the array has no reset.
module regfile_scoreboard #(
  parameter int NREGS = 32,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] sel_rs1_i,
  input  logic [$clog2(NREGS)-1:0] sel_rs2_i,
  output logic [XLEN-1:0]          rs1_o,
  output logic [XLEN-1:0]          rs2_o,
  output logic                     rs1_busy_o,
  output logic                     rs2_busy_o,
  input  logic [$clog2(NREGS)-1:0] sel_rd_i,
  input  logic                     we_i,
  input  logic [XLEN-1:0]          data_i,
  input  logic                     mark_i,
  input  logic [$clog2(NREGS)-1:0] sel_mark_i,
  input  logic                     flush_i
);

  localparam int AW = $clog2(NREGS);

  // x0 has no storage; it is synthesised as a constant zero on both read ports.
  logic [XLEN-1:0]  regs [1:NREGS-1];
  logic [NREGS-1:1] busy_q;
  logic [NREGS-1:1] busy_d;
  logic             wr_en;

  assign wr_en = we_i && (sel_rd_i != '0);

`ifdef REGFILE_RESET_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int r = 1; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_en) begin
      regs[sel_rd_i] <= data_i;
    end
  end
`else
  // NOTE: the array is deliberately left out of reset so it maps onto plain
  // storage; only the write is gated so a write during reset is still dropped.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      regs[sel_rd_i] <= data_i;
    end
  end
`endif

  // Per-bit priority: flush, then a new mark, then a completing write.
  always_comb begin
    // NOTE: default first so every path assigns busy_d and no latch is inferred.
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (flush_i) begin
        busy_d[r] = 1'b0;
      end else if (mark_i && (sel_mark_i == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (we_i && (sel_rd_i == AW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rs1_o = '0;
    if (sel_rs1_i != '0) begin
      if (we_i && (sel_rd_i == sel_rs1_i)) begin
        rs1_o = data_i;
      end else begin
        rs1_o = regs[sel_rs1_i];
      end
    end
  end

  always_comb begin
    rs2_o = '0;
    if (sel_rs2_i != '0) begin
      if (we_i && (sel_rd_i == sel_rs2_i)) begin
        rs2_o = data_i;
      end else begin
        rs2_o = regs[sel_rs2_i];
      end
    end
  end

  // A write completing this cycle resolves the hazard because the bypass supplies its data.
  always_comb begin
    rs1_busy_o = 1'b0;
    rs2_busy_o = 1'b0;
    if (sel_rs1_i != '0) begin
      rs1_busy_o = busy_q[sel_rs1_i] && !(we_i && (sel_rd_i == sel_rs1_i));
    end
    if (sel_rs2_i != '0) begin
      rs2_busy_o = busy_q[sel_rs2_i] && !(we_i && (sel_rd_i == sel_rs2_i));
    end
  end

endmodule
